// File: rtl/music_sequencer_if.sv
// Control, song-write and note-output bundle between host and music_sequencer.
// The host drives the master side; the sequencer uses the slave side.
interface music_sequencer_if;
  logic       play;
  logic       stop;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] code;
  logic [4:0] note_idx;
  logic       playing;
  logic       done;

  modport master (
    output play, stop, wr_en, wr_addr, wr_data,
    input  code, note_idx, playing, done
  );

  modport slave (
    input  play, stop, wr_en, wr_addr, wr_data,
    output code, note_idx, playing, done
  );
endinterface

// File: rtl/music_sequencer.sv
// 32-entry song sequencer feeding the tone generator, with an articulation gap.
// Optional SEQ_LOOP_EN: wrap to entry 0 on end marker or entry 31.
module music_sequencer #(
  parameter int BEAT_DIV   = 12_500_000,
  parameter int GAP_CYCLES = 1_250_000
) (
  input logic              iclk,
  input logic              irst_n,
  music_sequencer_if.slave bus
);

  localparam logic [26:0] BEAT = 27'(BEAT_DIV);
  localparam logic [26:0] GAP  = 27'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_NOTE, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_mem [32];
  logic [26:0] r_rem, w_rem_nxt, w_dec;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [4:0]  r_lat, w_lat_nxt;
  logic [4:0]  r_code, w_code_nxt;
  logic        r_playing, w_playing_nxt;
  logic        r_done, w_done_nxt;
  logic [7:0]  w_entry;
  logic [2:0]  w_dur;
  logic [4:0]  w_raw, w_filt;
  logic        w_valid, w_last;

  assign w_entry = r_mem[r_idx];
  assign w_dur   = w_entry[7:5];
  assign w_raw   = w_entry[4:0];
  assign w_valid = (w_raw <= 5'd7)
                || (w_raw >= 5'd11 && w_raw <= 5'd17)
                || (w_raw >= 5'd21 && w_raw <= 5'd27);
  assign w_filt  = w_valid ? w_raw : 5'd0;
  assign w_last  = (r_idx == 5'd31);
  assign w_dec   = r_rem - 27'd1;

  // Memory is only writable while nothing is being played.
  always_ff @(posedge iclk) begin
    if (bus.wr_en && !r_playing)
      r_mem[bus.wr_addr] <= bus.wr_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_idx_nxt   = r_idx;
    w_lat_nxt   = r_lat;
    w_code_nxt  = 5'd0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.play) begin
          w_idx_nxt   = 5'd0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_dur != 3'd0) begin
          w_rem_nxt   = 27'(w_dur) * BEAT;
          w_lat_nxt   = w_filt;
          w_code_nxt  = w_filt;
          w_state_nxt = S_NOTE;
        end else begin
          w_done_nxt = 1'b1;
`ifdef SEQ_LOOP_EN
          if (r_idx != 5'd0) begin
            w_idx_nxt   = 5'd0;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_DONE;
          end
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
      S_NOTE: begin
        w_rem_nxt = w_dec;
        if (r_rem == 27'd1) begin
          if (w_last) begin
            w_done_nxt = 1'b1;
`ifdef SEQ_LOOP_EN
            w_idx_nxt   = 5'd0;
            w_state_nxt = S_FETCH;
`else
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_idx_nxt   = r_idx + 5'd1;
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_code_nxt = (w_dec > GAP) ? r_lat : 5'd0;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.stop) begin
      w_state_nxt = S_IDLE;
      w_rem_nxt   = 27'd0;
      w_code_nxt  = 5'd0;
      w_done_nxt  = 1'b0;
    end
    w_playing_nxt = (w_state_nxt == S_FETCH)
                 || (w_state_nxt == S_NOTE);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state   <= S_IDLE;
      r_rem     <= 27'd0;
      r_idx     <= 5'd0;
      r_lat     <= 5'd0;
      r_code    <= 5'd0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      r_idx     <= w_idx_nxt;
      r_lat     <= w_lat_nxt;
      r_code    <= w_code_nxt;
      r_playing <= w_playing_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.code     = r_code;
  assign bus.note_idx = r_idx;
  assign bus.playing  = r_playing;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with BEAT_DIV=10, GAP_CYCLES=2.
// Sample s[j] is the output value seen at edge k+j after play at edge k.
module tb_music_sequencer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  logic [4:0] tr_code [64];
  logic [4:0] tr_idx  [64];
  logic       tr_play [64];
  logic       tr_done [64];

  music_sequencer_if bus();

  music_sequencer #(
    .BEAT_DIV   (10),
    .GAP_CYCLES (2)
  ) dut (
    .iclk   (clk),
    .irst_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_play();
    @(negedge clk);
    bus.play = 1'b1;
    @(negedge clk);
    bus.play = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic trace(input int n);
    for (int j = 1; j <= n; j++) begin
      if (j > 1) @(negedge clk);
      tr_code[j] = bus.code;
      tr_idx[j]  = bus.note_idx;
      tr_play[j] = bus.playing;
      tr_done[j] = bus.done;
    end
  endtask

  task automatic t_reset_state();
    chk("rst_code", 32'(bus.code), 0);
    chk("rst_idx", 32'(bus.note_idx), 0);
    chk("rst_play", 32'(bus.playing), 0);
    chk("rst_done", 32'(bus.done), 0);
  endtask

  task automatic t_single();
    wr(5'd0, {3'd2, 5'd11});
    wr(5'd1, 8'd0);
    pulse_play();
    trace(25);
    chk("one_fetch_code", 32'(tr_code[1]), 0);
    chk("one_fetch_play", 32'(tr_play[1]), 1);
    for (int j = 2; j <= 19; j++)
      chk($sformatf("one_code_s%0d", j), 32'(tr_code[j]), 11);
    chk("one_gap_s20", 32'(tr_code[20]), 0);
    chk("one_gap_s21", 32'(tr_code[21]), 0);
    chk("one_fetch2_play", 32'(tr_play[22]), 1);
    chk("one_fetch2_done", 32'(tr_done[22]), 0);
    chk("one_done_s23", 32'(tr_done[23]), 1);
    chk("one_idle_play", 32'(tr_play[24]), 0);
    chk("one_idle_done", 32'(tr_done[24]), 0);
    chk("one_idle_code", 32'(tr_code[24]), 0);
  endtask

  task automatic t_sequence();
    logic [4:0] vals [6];
    int         cnts [6];
    int         s;
    vals = '{5'd1, 5'd0, 5'd1, 5'd0, 5'd21, 5'd0};
    cnts = '{8, 3, 8, 3, 8, 2};
    wr(5'd0, {3'd1, 5'd1});
    wr(5'd1, {3'd1, 5'd1});
    wr(5'd2, {3'd1, 5'd21});
    wr(5'd3, 8'd0);
    pulse_play();
    trace(36);
    chk("seq_s1", 32'(tr_code[1]), 0);
    s = 2;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < cnts[r]; c++) begin
        chk($sformatf("seq_s%0d", s), 32'(tr_code[s]), 32'(vals[r]));
        s++;
      end
    chk("seq_idx_s5", 32'(tr_idx[5]), 0);
    chk("seq_idx_s16", 32'(tr_idx[16]), 1);
    chk("seq_idx_s27", 32'(tr_idx[27]), 2);
    chk("seq_done_s34", 32'(tr_done[34]), 0);
    chk("seq_done_s35", 32'(tr_done[35]), 1);
    chk("seq_play_s36", 32'(tr_play[36]), 0);
  endtask

  task automatic t_invalid();
    logic [4:0] acc;
    wr(5'd0, {3'd1, 5'd9});
    wr(5'd1, 8'd0);
    pulse_play();
    trace(14);
    acc = '0;
    for (int j = 1; j <= 12; j++) acc = acc | tr_code[j];
    chk("inv_code_or", 32'(acc), 0);
    chk("inv_play_s6", 32'(tr_play[6]), 1);
    chk("inv_idx_s12", 32'(tr_idx[12]), 1);
    chk("inv_done_s13", 32'(tr_done[13]), 1);
  endtask

  task automatic t_stop_lock();
    logic seen;
    wr(5'd0, {3'd2, 5'd3});
    wr(5'd1, 8'd0);
    pulse_play();
    trace(5);
    chk("stp_code_s5", 32'(tr_code[5]), 3);
    wr(5'd0, {3'd1, 5'd5});
    pulse_stop();
    chk("stp_code", 32'(bus.code), 0);
    chk("stp_play", 32'(bus.playing), 0);
    chk("stp_done", 32'(bus.done), 0);
    seen = 1'b0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      seen = seen | bus.done;
    end
    chk("stp_no_done", 32'(seen), 0);
    pulse_play();
    trace(3);
    chk("lock_code", 32'(tr_code[2]), 3);
    pulse_stop();
  endtask

  task automatic t_reset_mid();
    wr(5'd0, {3'd1, 5'd1});
    wr(5'd1, {3'd1, 5'd1});
    wr(5'd2, {3'd1, 5'd21});
    wr(5'd3, 8'd0);
    pulse_play();
    trace(16);
    chk("rm_pre_idx", 32'(tr_idx[16]), 1);
    chk("rm_pre_code", 32'(tr_code[16]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_code", 32'(bus.code), 0);
    chk("rm_play", 32'(bus.playing), 0);
    chk("rm_idx", 32'(bus.note_idx), 0);
    chk("rm_done", 32'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_play();
    trace(2);
    chk("rm_restart_idx", 32'(tr_idx[1]), 0);
    chk("rm_restart_code", 32'(tr_code[2]), 1);
    pulse_stop();
  endtask

`ifdef SEQ_LOOP_EN
  task automatic t_loop();
    int dn;
    wr(5'd0, {3'd1, 5'd2});
    wr(5'd1, {3'd1, 5'd3});
    wr(5'd2, 8'd0);
    pulse_play();
    trace(26);
    chk("lp_done_s23", 32'(tr_done[23]), 0);
    chk("lp_done_s24", 32'(tr_done[24]), 1);
    chk("lp_idx_s24", 32'(tr_idx[24]), 0);
    chk("lp_play_s24", 32'(tr_play[24]), 1);
    chk("lp_done_s25", 32'(tr_done[25]), 0);
    chk("lp_code_s25", 32'(tr_code[25]), 2);
    pulse_stop();
    wr(5'd0, 8'd0);
    pulse_play();
    trace(6);
    dn = 0;
    for (int j = 1; j <= 6; j++) dn += int'(tr_done[j]);
    chk("lp0_done_cnt", 32'(dn), 1);
    chk("lp0_done_s2", 32'(tr_done[2]), 1);
    chk("lp0_play_s6", 32'(tr_play[6]), 0);
  endtask
`endif

  initial begin
    n_chk       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    bus.play    = 1'b0;
    bus.stop    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 5'd0;
    bus.wr_data = 8'd0;
    repeat (3) @(negedge clk);
    t_reset_state();
    rst_n = 1'b1;
    @(negedge clk);
`ifdef SEQ_LOOP_EN
    t_stop_lock();
    t_reset_mid();
    t_loop();
`else
    t_single();
    t_sequence();
    t_invalid();
    t_stop_lock();
    t_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
